// File: rtl/arp_rx_if.sv
// Receive byte-stream bus from the Ethernet MAC into the ARP parser.
interface arp_rx_if;
  logic [7:0] i_rx_data;
  logic       i_rx_valid;
  logic       i_rx_sop;
  logic       i_rx_eop;
  logic       i_rx_err;

  modport master (output i_rx_data, i_rx_valid, i_rx_sop, i_rx_eop, i_rx_err);
  modport slave  (input  i_rx_data, i_rx_valid, i_rx_sop, i_rx_eop, i_rx_err);
endinterface

// File: rtl/arp_rx_parser.sv
// ARP/Ethernet receive parser: shadows header and ARP fields, commits them atomically at eop.
// Optional destination-MAC filter enabled by defining ARP_RX_MAC_FILTER_EN.
module arp_rx_parser #(
  parameter int MIN_FRAME = 42,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  arp_rx_if.slave          rx,
  input  logic [47:0]      i_my_mac,
  output logic [47:0]      o_dst_mac,
  output logic [47:0]      o_src_mac,
  output logic [1:0]       o_operation,
  output logic [47:0]      o_SHA,
  output logic [31:0]      o_SPA,
  output logic [47:0]      o_THA,
  output logic [31:0]      o_TPA,
  output logic [1:0]       o_packet_type,
  output logic             o_pkt_valid,
  output logic [CNT_W-1:0] o_rx_cnt,
  output logic [CNT_W-1:0] o_drop_cnt
);

  typedef enum logic [1:0] {IDLE, HDR, ARP, SKIP} state_t;

  state_t      state;
  logic [5:0]  cnt;
  logic [47:0] dst_sh, src_sh, sha_sh, tha_sh;
  logic [31:0] spa_sh, tpa_sh;
  logic [15:0] htype_sh, ptype_sh, oper_sh;
  logic [7:0]  etype_hi, hlen_sh, plen_sh;
  logic        err_q;
  logic [1:0]  cls_q;
  logic        vld_p0;
  logic [1:0]  cls_p0;
  logic [1:0]  drop_p0;

  function automatic logic [5:0] sat_inc(input logic [5:0] v);
    return (v == 6'd63) ? v : v + 6'd1;
  endfunction

  function automatic logic [1:0] classify(input logic [15:0] et);
    if (et == 16'h0806) return 2'd1;
    if (et == 16'h0800) return 2'd2;
    return 2'd3;
  endfunction

  function automatic logic arp_body_ok(input logic [15:0] ht, input logic [15:0] pt,
                                       input logic [7:0] hl, input logic [7:0] pl,
                                       input logic [15:0] op);
    return (ht == 16'h0001) && (pt == 16'h0800) && (hl == 8'd6) && (pl == 8'd4) &&
           ((op == 16'd1) || (op == 16'd2));
  endfunction

  logic [7:0]  d;
  logic [5:0]  off;
  logic        store;
  logic [15:0] etype_now;
  logic [1:0]  cls_raw, cls_fin;
  logic [6:0]  len_now;
  logic        len_ok, err_now, mac_ok, frame_good;

  assign d         = rx.i_rx_data;
  assign off       = rx.i_rx_sop ? 6'd0 : cnt;
  assign store     = rx.i_rx_valid && (rx.i_rx_sop || state == HDR || state == ARP);
  assign etype_now = {etype_hi, d};
  // In HDR the eop byte may itself complete the ethertype, so classify from the live byte.
  assign cls_raw   = (state == HDR) ? classify(etype_now) : cls_q;
  assign cls_fin   = (cls_raw == 2'd1 &&
                      !arp_body_ok(htype_sh, ptype_sh, hlen_sh, plen_sh, oper_sh)) ? 2'd3 : cls_raw;
  assign len_now   = {1'b0, cnt} + 7'd1;
  assign len_ok    = (cls_raw == 2'd1) ? (int'(len_now) >= MIN_FRAME) : (len_now >= 7'd14);
  assign err_now   = err_q | rx.i_rx_err;

`ifdef ARP_RX_MAC_FILTER_EN
  logic mac_ok_q;
  assign mac_ok = mac_ok_q;
`else
  logic unused_my_mac;
  assign unused_my_mac = ^i_my_mac;
  assign mac_ok = 1'b1;
`endif

  assign frame_good = !err_now && len_ok && mac_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;  cnt <= '0;  err_q <= 1'b0;  cls_q <= '0;
      dst_sh <= '0;  src_sh <= '0;  sha_sh <= '0;  tha_sh <= '0;
      spa_sh <= '0;  tpa_sh <= '0;  htype_sh <= '0;  ptype_sh <= '0;
      oper_sh <= '0;  etype_hi <= '0;  hlen_sh <= '0;  plen_sh <= '0;
      vld_p0 <= 1'b0;  cls_p0 <= '0;  drop_p0 <= '0;
      o_dst_mac <= '0;  o_src_mac <= '0;  o_operation <= '0;
      o_SHA <= '0;  o_SPA <= '0;  o_THA <= '0;  o_TPA <= '0;
      o_packet_type <= '0;  o_pkt_valid <= 1'b0;
      o_rx_cnt <= '0;  o_drop_cnt <= '0;
`ifdef ARP_RX_MAC_FILTER_EN
      mac_ok_q <= 1'b0;
`endif
    end else begin
      // Commit stage: one cycle after the eop byte, shadows already hold that byte.
      vld_p0      <= 1'b0;
      drop_p0     <= '0;
      o_pkt_valid <= vld_p0;
      o_drop_cnt  <= o_drop_cnt + CNT_W'(drop_p0);
      if (vld_p0) begin
        o_dst_mac     <= dst_sh;
        o_src_mac     <= src_sh;
        o_packet_type <= cls_p0;
        o_rx_cnt      <= o_rx_cnt + CNT_W'(1);
        if (cls_p0 == 2'd1) begin
          o_operation <= oper_sh[1:0];
          o_SHA <= sha_sh;  o_SPA <= spa_sh;  o_THA <= tha_sh;  o_TPA <= tpa_sh;
        end
      end

      // Parse stage: shift each accepted byte into the field its offset selects.
      if (store) begin
        case (off) inside
          [6'd0:6'd5]:   dst_sh   <= {dst_sh[39:0], d};
          [6'd6:6'd11]:  src_sh   <= {src_sh[39:0], d};
          6'd12:         etype_hi <= d;
          [6'd14:6'd15]: htype_sh <= {htype_sh[7:0], d};
          [6'd16:6'd17]: ptype_sh <= {ptype_sh[7:0], d};
          6'd18:         hlen_sh  <= d;
          6'd19:         plen_sh  <= d;
          [6'd20:6'd21]: oper_sh  <= {oper_sh[7:0], d};
          [6'd22:6'd27]: sha_sh   <= {sha_sh[39:0], d};
          [6'd28:6'd31]: spa_sh   <= {spa_sh[23:0], d};
          [6'd32:6'd37]: tha_sh   <= {tha_sh[39:0], d};
          [6'd38:6'd41]: tpa_sh   <= {tpa_sh[23:0], d};
          default: ;
        endcase
      end

      if (rx.i_rx_valid) begin
        if (rx.i_rx_sop) begin
          // A sop mid-frame aborts the old frame; sop with eop is a runt. Both count as drops.
          drop_p0 <= {1'b0, state != IDLE} + {1'b0, rx.i_rx_eop};
          cnt     <= 6'd1;
          err_q   <= rx.i_rx_err;
          cls_q   <= '0;
          state   <= rx.i_rx_eop ? IDLE : HDR;
`ifdef ARP_RX_MAC_FILTER_EN
          mac_ok_q <= 1'b0;
`endif
        end else if (state != IDLE) begin
          cnt   <= sat_inc(cnt);
          err_q <= err_now;
`ifdef ARP_RX_MAC_FILTER_EN
          if (state == HDR && cnt == 6'd5)
            mac_ok_q <= ({dst_sh[39:0], d} == 48'hFFFF_FFFF_FFFF) ||
                        ({dst_sh[39:0], d} == i_my_mac);
`endif
          if (state == HDR && cnt == 6'd13) begin
            cls_q <= classify(etype_now);
            state <= (etype_now == 16'h0806) ? ARP : SKIP;
          end
          if (state == ARP && cnt == 6'd41) state <= SKIP;
          if (rx.i_rx_eop) begin
            state <= IDLE;
            if (frame_good) begin
              vld_p0 <= 1'b1;
              cls_p0 <= cls_fin;
            end else begin
              drop_p0 <= 2'd1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_arp_rx_parser.sv
// Scoreboard bench for arp_rx_parser; define ARP_RX_MAC_FILTER_EN to exercise the address filter.
module tb_arp_rx_parser;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [47:0] my_mac = 48'h02_00_00_00_00_01;
  logic [47:0] o_dst_mac, o_src_mac, o_SHA, o_THA;
  logic [31:0] o_SPA, o_TPA;
  logic [1:0]  o_operation, o_packet_type;
  logic        o_pkt_valid;
  logic [15:0] o_rx_cnt, o_drop_cnt;

  arp_rx_if rx();

  arp_rx_parser #(.MIN_FRAME(42), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .rx(rx), .i_my_mac(my_mac),
    .o_dst_mac(o_dst_mac), .o_src_mac(o_src_mac), .o_operation(o_operation),
    .o_SHA(o_SHA), .o_SPA(o_SPA), .o_THA(o_THA), .o_TPA(o_TPA),
    .o_packet_type(o_packet_type), .o_pkt_valid(o_pkt_valid),
    .o_rx_cnt(o_rx_cnt), .o_drop_cnt(o_drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pulse;
    logic [47:0] dst, src, sha, tha;
    logic [31:0] spa, tpa;
    logic [1:0]  ptype, oper;
    logic [15:0] rx_n, drop_n;
  } exp_t;

  exp_t sb[$];
  exp_t mdl;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [7:0]  fb [128];
  logic [47:0] f_dst, f_src, f_sha, f_tha;
  logic [31:0] f_spa, f_tpa;
  logic [1:0]  f_oper;
  logic        eop_mark = 1'b0;
  logic        m1 = 1'b0, m2 = 1'b0, m3 = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic build_arp(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] htype,
                           input logic [1:0] oper, input logic [47:0] sha, input logic [31:0] spa,
                           input logic [47:0] tha, input logic [31:0] tpa);
    for (int i = 0; i < 128; i++) fb[i] = 8'h00;
    for (int i = 0; i < 6; i++) begin
      fb[i]    = dst[47-8*i -: 8];
      fb[6+i]  = src[47-8*i -: 8];
      fb[22+i] = sha[47-8*i -: 8];
      fb[32+i] = tha[47-8*i -: 8];
    end
    for (int i = 0; i < 4; i++) begin
      fb[28+i] = spa[31-8*i -: 8];
      fb[38+i] = tpa[31-8*i -: 8];
    end
    fb[12] = 8'h08;  fb[13] = 8'h06;
    fb[14] = htype[15:8];  fb[15] = htype[7:0];
    fb[16] = 8'h08;  fb[17] = 8'h00;  fb[18] = 8'd6;  fb[19] = 8'd4;
    fb[20] = 8'h00;  fb[21] = {6'd0, oper};
    f_dst = dst;  f_src = src;  f_oper = oper;
    f_sha = sha;  f_spa = spa;  f_tha = tha;  f_tpa = tpa;
  endtask

  task automatic build_ip(input logic [47:0] dst, input logic [47:0] src);
    for (int i = 0; i < 128; i++) fb[i] = 8'(i * 7 + 3);
    for (int i = 0; i < 6; i++) begin
      fb[i]   = dst[47-8*i -: 8];
      fb[6+i] = src[47-8*i -: 8];
    end
    fb[12] = 8'h08;  fb[13] = 8'h00;
    f_dst = dst;  f_src = src;
  endtask

  task automatic expect_frame(input bit accept, input logic [1:0] cls);
    exp_t e;
    if (accept) begin
      mdl.dst = f_dst;  mdl.src = f_src;  mdl.ptype = cls;
      if (cls == 2'd1) begin
        mdl.oper = f_oper;  mdl.sha = f_sha;  mdl.spa = f_spa;
        mdl.tha = f_tha;    mdl.tpa = f_tpa;
      end
      mdl.rx_n++;
    end else begin
      mdl.drop_n++;
    end
    e = mdl;
    e.pulse = accept;
    sb.push_back(e);
  endtask

  task automatic drive_frame(input int n, input bit do_eop, input bit err_last, input int gap_max);
    for (int i = 0; i < n; i++) begin
      if (gap_max > 0) begin
        repeat ($urandom_range(gap_max, 0)) begin
          rx.i_rx_valid = 1'b0;  rx.i_rx_sop = 1'b1;  rx.i_rx_eop = 1'b1;
          rx.i_rx_data  = 8'($urandom);
          @(posedge clk); #1;
        end
      end
      rx.i_rx_valid = 1'b1;
      rx.i_rx_data  = fb[i];
      rx.i_rx_sop   = (i == 0);
      rx.i_rx_eop   = do_eop && (i == n - 1);
      rx.i_rx_err   = err_last && (i == n - 1);
      eop_mark      = do_eop && (i == n - 1);
      @(posedge clk); #1;
    end
    rx.i_rx_valid = 1'b0;  rx.i_rx_sop = 1'b0;  rx.i_rx_eop = 1'b0;
    rx.i_rx_err   = 1'b0;  eop_mark = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Result stage: outputs are due one clock after the eop byte is taken.
  always @(posedge clk) begin
    m1 <= eop_mark;
    m2 <= m1;
    m3 <= m2;
  end

  always @(negedge clk) begin
    if (m2) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 64'(1), 64'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("pkt_valid", 64'(o_pkt_valid), 64'(e.pulse));
        check("dst_mac", 64'(o_dst_mac), 64'(e.dst));
        check("src_mac", 64'(o_src_mac), 64'(e.src));
        check("pkt_type", 64'(o_packet_type), 64'(e.ptype));
        check("operation", 64'(o_operation), 64'(e.oper));
        check("SHA", 64'(o_SHA), 64'(e.sha));
        check("SPA", 64'(o_SPA), 64'(e.spa));
        check("THA", 64'(o_THA), 64'(e.tha));
        check("TPA", 64'(o_TPA), 64'(e.tpa));
        check("rx_cnt", 64'(o_rx_cnt), 64'(e.rx_n));
        check("drop_cnt", 64'(o_drop_cnt), 64'(e.drop_n));
      end
    end
    if (m3) check("pulse_width", 64'(o_pkt_valid), 64'(0));
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rx.i_rx_valid = 1'b0;  rx.i_rx_sop = 1'b0;  rx.i_rx_eop = 1'b0;
    rx.i_rx_err   = 1'b0;  rx.i_rx_data = 8'h00;
    mdl = '{pulse: 1'b0, dst: '0, src: '0, sha: '0, tha: '0, spa: '0, tpa: '0,
            ptype: '0, oper: '0, rx_n: '0, drop_n: '0};
    idle(3);
    rst = 1'b0;
    idle(2);
    @(negedge clk);
    check("rst_dst", 64'(o_dst_mac), 64'(0));
    check("rst_type", 64'(o_packet_type), 64'(0));
    check("rst_SPA", 64'(o_SPA), 64'(0));
    check("rst_valid", 64'(o_pkt_valid), 64'(0));
    check("rst_rx_cnt", 64'(o_rx_cnt), 64'(0));
    check("rst_drop_cnt", 64'(o_drop_cnt), 64'(0));
    @(posedge clk); #1;

    // Broadcast ARP request, 60 bytes.
    build_arp(48'hFFFF_FFFF_FFFF, 48'h0011_2233_4455, 16'h0001, 2'd1,
              48'h0011_2233_4455, 32'hC0A8_0001, 48'h0, 32'hC0A8_000A);
    expect_frame(1'b1, 2'd1);
    drive_frame(60, 1'b1, 1'b0, 0);
    idle(5);

    // IPv4 frame, 64 bytes: MACs and class change, ARP fields hold.
    build_ip(my_mac, 48'hA0B0_C0D0_E0F0);
    expect_frame(1'b1, 2'd2);
    drive_frame(64, 1'b1, 1'b0, 0);
    idle(5);

    // ARP with MAC error on the last byte.
    build_arp(48'hFFFF_FFFF_FFFF, 48'h0066_7788_99AA, 16'h0001, 2'd2,
              48'h0066_7788_99AA, 32'h0A00_0001, 48'h1, 32'h0A00_0002);
    expect_frame(1'b0, 2'd1);
    drive_frame(60, 1'b1, 1'b1, 0);
    idle(5);

    // ARP truncated with eop at byte 30.
    expect_frame(1'b0, 2'd1);
    drive_frame(31, 1'b1, 1'b0, 0);
    idle(5);

    // Aborted ARP (sop re-asserted at byte 20), then a full gapped ARP reply.
    build_arp(48'hFFFF_FFFF_FFFF, 48'h0011_2233_4455, 16'h0001, 2'd1,
              48'h0011_2233_4455, 32'hC0A8_0005, 48'h0, 32'hC0A8_0006);
    drive_frame(20, 1'b0, 1'b0, 0);
    mdl.drop_n++;
    build_arp(48'h0011_2233_4455, 48'h0200_0000_0001, 16'h0001, 2'd2,
              48'h0200_0000_0001, 32'hC0A8_000A, 48'h0011_2233_4455, 32'hC0A8_0001);
    expect_frame(1'b1, 2'd1);
    drive_frame(60, 1'b1, 1'b0, 3);
    idle(5);

    // Runt: sop and eop on the same byte.
    expect_frame(1'b0, 2'd0);
    drive_frame(1, 1'b1, 1'b0, 0);
    idle(5);

    // Stray valid bytes without sop are ignored (no record, no count change).
    rx.i_rx_valid = 1'b1;  rx.i_rx_data = 8'h55;  rx.i_rx_eop = 1'b1;
    idle(3);
    rx.i_rx_valid = 1'b0;  rx.i_rx_eop = 1'b0;
    idle(2);

    // ARP with bad HTYPE, 100 bytes: class 3, MACs update, ARP fields hold.
    build_arp(48'hFFFF_FFFF_FFFF, 48'h00DE_ADBE_EF00, 16'h0006, 2'd1,
              48'h00DE_ADBE_EF00, 32'h1111_1111, 48'h0, 32'h2222_2222);
    expect_frame(1'b1, 2'd3);
    drive_frame(100, 1'b1, 1'b0, 0);
    idle(5);

    // Unicast ARP to an address other than the local MAC.
    build_arp(48'h0200_0000_0002, 48'h0033_4455_6677, 16'h0001, 2'd1,
              48'h0033_4455_6677, 32'hC0A8_0101, 48'h0, 32'hC0A8_0102);
`ifdef ARP_RX_MAC_FILTER_EN
    expect_frame(1'b0, 2'd1);
`else
    expect_frame(1'b1, 2'd1);
`endif
    drive_frame(60, 1'b1, 1'b0, 0);
    idle(5);

    // Same frame to the local MAC: always accepted.
    build_arp(48'h0200_0000_0001, 48'h0033_4455_6677, 16'h0001, 2'd1,
              48'h0033_4455_6677, 32'hC0A8_0101, 48'h0, 32'hC0A8_0102);
    expect_frame(1'b1, 2'd1);
    drive_frame(60, 1'b1, 1'b0, 2);
    idle(8);

    check("sb_drained", 64'(sb.size()), 64'(0));
    check("final_rx_cnt", 64'(o_rx_cnt), 64'(mdl.rx_n));
    check("final_drop_cnt", 64'(o_drop_cnt), 64'(mdl.drop_n));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/arp_rx_parser.md
Name: arp_rx_parser

Overview:
- Byte-stream parser between the Ethernet MAC receive path and the status register block.
- Extracts the Ethernet header and ARP payload fields from each received frame.
- Classifies each frame and holds the last good frame's fields in stable output registers for CPU readout.
- Fields commit atomically at end-of-frame, so readout never sees a half-updated packet.

Parameters:
- MIN_FRAME, 42, minimum byte count (header + ARP body) required for a frame to be accepted.
- CNT_W, 16, width of the frame/drop statistics counters.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- i_rx_data  input  8  receive byte.
- i_rx_valid  input  1  byte qualifier; gaps allowed at any point.
- i_rx_sop  input  1  first byte of frame; qualified by i_rx_valid.
- i_rx_eop  input  1  last byte of frame; qualified by i_rx_valid.
- i_rx_err  input  1  MAC error (FCS/PHY) flag; sampled on any valid byte.
- i_my_mac  input  48  local MAC address; used only when the filter is enabled.
- o_dst_mac  output  48  destination MAC of last accepted frame.
- o_src_mac  output  48  source MAC of last accepted frame.
- o_operation  output  2  ARP operation: 1 = request, 2 = reply.
- o_SHA  output  48  sender hardware address.
- o_SPA  output  32  sender protocol address.
- o_THA  output  48  target hardware address.
- o_TPA  output  32  target protocol address.
- o_packet_type  output  2  class of last accepted frame: 0 = none, 1 = ARP, 2 = IPv4, 3 = other.
- o_pkt_valid  output  1  one-cycle pulse when outputs are updated.
- o_rx_cnt  output  CNT_W  accepted-frame counter.
- o_drop_cnt  output  CNT_W  dropped-frame counter.

Behaviour:
- Reset: all outputs 0. FSM goes to IDLE. Byte counter 0. Shadow registers 0.
- Byte offsets (big-endian, first byte is MSB):
  - dst 0-5; src 6-11; ethertype 12-13.
  - HTYPE 14-15; PTYPE 16-17; HLEN 18; PLEN 19; OPER 20-21.
  - SHA 22-27; SPA 28-31; THA 32-37; TPA 38-41.
- Each valid byte is shifted into the shadow register selected by the byte counter. The counter increments only on i_rx_valid.
- FSM states:
  - IDLE: a valid byte with sop goes to HDR at count 1. Valid bytes without sop are ignored.
  - HDR (bytes 0-13): at byte 13, ethertype 0x0806 goes to ARP; any other value goes to SKIP with class 2 (0x0800) or 3.
  - ARP (bytes 14-41): body checks are HTYPE = 0x0001, PTYPE = 0x0800, HLEN = 6, PLEN = 4, OPER in {1,2}.
    - Any failed check sets a bad flag; the frame is then classed 3.
    - After byte 41, go to SKIP.
  - SKIP: consume padding/trailer until eop.
- End-of-frame handling on the eop byte:
  - The frame is good if the error flag is clear and byte count ≥ MIN_FRAME. Non-ARP frames need only ≥ 14 bytes.
  - Good frame, the following cycle:
    - o_dst_mac, o_src_mac and o_packet_type update.
    - ARP fields and o_operation update only when class = 1.
    - o_pkt_valid pulses for 1 cycle; o_rx_cnt increments.
  - Bad frame: outputs hold, o_drop_cnt increments, no pulse.
  - The FSM returns to IDLE in both cases.
- Latency: outputs change exactly 1 clk after the eop byte is accepted.
- Error flag: sticky per frame. It is set by i_rx_err on any valid byte, including the eop byte, and cleared at sop.
- SOP while not in IDLE: abort the current frame (counted as drop) and start a new frame on this byte.
- sop and eop on the same byte: runt frame, counted as drop.
- The byte counter saturates at 63 (ARP offsets need no more), so long frames never wrap into field offsets.
- Counters wrap modulo 2^CNT_W.
- rst asserted mid-frame: immediate return to reset state; the partial frame is not counted.

Optional Feature:
- Macro: ARP_RX_MAC_FILTER_EN.
- When defined:
  - A frame is accepted only if dst_mac = FF:FF:FF:FF:FF:FF or dst_mac = i_my_mac.
  - Any other frame is dropped: o_drop_cnt increments and outputs hold.
  - The comparison completes by byte 6; the result is held in a flag.
- When undefined: no address filtering, and i_my_mac is unused.

Test Plan:
- Broadcast ARP request:
  - Stimulus: dst FFFFFFFFFFFF, src 001122334455, OPER 1, SHA 001122334455, SPA C0A80001, THA 0, TPA C0A8000A, padded to 60 bytes.
  - Response: 1 clk after eop, o_packet_type = 1, o_operation = 1, o_SPA = C0A80001, o_TPA = C0A8000A, o_pkt_valid 1-cycle pulse, o_rx_cnt = 1.
- IPv4 frame (ethertype 0x0800, 64 bytes) after the above:
  - Response: o_packet_type = 2, MACs update, o_SPA still C0A80001.
- ARP frame with i_rx_err on the last byte:
  - Response: no pulse, outputs unchanged, o_drop_cnt = 1.
- ARP frame truncated with eop at byte 30:
  - Response: dropped, o_drop_cnt increments.
- SOP reasserted at byte 20 of an ARP frame, followed by a complete ARP reply (OPER 2) with random i_rx_valid gaps:
  - Response: o_drop_cnt +1, o_operation = 2, o_rx_cnt +1.
- With ARP_RX_MAC_FILTER_EN, i_my_mac = 020000000001, unicast frame to 020000000002:
  - Response: dropped.
  - Same frame sent to 020000000001: accepted.
